// File: rtl/vram_access_ctrl.sv
// Arbiter and rectangle-fill sequencer in front of the GPU's CPU-side VRAM port.
// CPU accesses always win; the fill engine writes one pixel per idle port cycle.
module vram_access_ctrl #(
    parameter int unsigned H_RES  = 200,
    parameter int unsigned V_RES  = 150,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_we_i,
    input  logic              cpu_re_i,
    input  logic [15:0]       cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    input  logic [DATA_W-1:0] cpu_rdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_rvalid_o,
    input  logic              fill_start_i,
    input  logic              fill_abort_i,
    input  logic [7:0]        fill_x0_i,
    input  logic [7:0]        fill_x1_i,
    input  logic [7:0]        fill_y0_i,
    input  logic [7:0]        fill_y1_i,
    input  logic [DATA_W-1:0] fill_color_i,
    output logic              fill_busy_o,
    output logic              fill_done_o,
    output logic              fill_err_o,
    output logic              vram_we_o,
    output logic              vram_re_o,
    output logic [15:0]       vram_addr_o,
    output logic [DATA_W-1:0] vram_data_o
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [7:0]        x, y;
    logic [7:0]        x0_r, x1_r, y1_r;
    logic [DATA_W-1:0] color_r;

    logic              cpu_req;
    logic              req_valid;
    logic              start_ok;
    logic              fill_step;
    logic              last_px;

    logic              we_d, re_d, err_d;
    logic [15:0]       addr_d;
    logic [DATA_W-1:0] data_d;

    assign cpu_req   = cpu_we_i | cpu_re_i;
    assign req_valid = (fill_x0_i <= fill_x1_i) && (32'(fill_x1_i) < H_RES) &&
                       (fill_y0_i <= fill_y1_i) && (32'(fill_y1_i) < V_RES);
    assign start_ok  = (state == IDLE) && fill_start_i && req_valid;
    // A fill slot exists only when the CPU leaves the port free and no abort is pending.
    assign fill_step = (state == FILL) && !fill_abort_i && !cpu_req;
    assign last_px   = (x == x1_r) && (y == y1_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_ok) state_nxt = FILL;
            FILL: begin
                if (fill_abort_i) begin
                    state_nxt = IDLE;
                end else if (fill_step && last_px) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x       <= '0;
            y       <= '0;
            x0_r    <= '0;
            x1_r    <= '0;
            y1_r    <= '0;
            color_r <= '0;
        end else if (start_ok) begin
            x       <= fill_x0_i;
            y       <= fill_y0_i;
            x0_r    <= fill_x0_i;
            x1_r    <= fill_x1_i;
            y1_r    <= fill_y1_i;
            color_r <= fill_color_i;
        end else if (fill_step) begin
            if (x == x1_r) begin
                x <= x0_r;
                y <= y + 8'd1;
            end else begin
                x <= x + 8'd1;
            end
        end
    end

    always_comb begin
        we_d   = 1'b0;
        re_d   = 1'b0;
        addr_d = '0;
        data_d = '0;
        err_d  = (state == IDLE) && fill_start_i && !req_valid;
        if (cpu_we_i) begin
            we_d   = 1'b1;
            addr_d = cpu_addr_i;
            data_d = cpu_data_i;
        end else if (cpu_re_i) begin
            re_d   = 1'b1;
            addr_d = cpu_addr_i;
        end else if (fill_step) begin
            we_d   = 1'b1;
            addr_d = {y, x};
            data_d = color_r;
        end
    end

    // Read data comes back one cycle after vram_re_o, so rvalid is just a delayed copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_we_o    <= 1'b0;
            vram_re_o    <= 1'b0;
            vram_addr_o  <= '0;
            vram_data_o  <= '0;
            fill_err_o   <= 1'b0;
            cpu_rvalid_o <= 1'b0;
        end else begin
            vram_we_o    <= we_d;
            vram_re_o    <= re_d;
            vram_addr_o  <= addr_d;
            vram_data_o  <= data_d;
            fill_err_o   <= err_d;
            cpu_rvalid_o <= vram_re_o;
        end
    end

    assign cpu_rdata_o = cpu_rdata_i;
    assign fill_busy_o = (state != IDLE);
    assign fill_done_o = (state == DONE);

endmodule

// File: tb/tb_vram_access_ctrl.sv
// Self-checking bench for vram_access_ctrl: table of fill requests plus hand
// sequences, with a write/read scoreboard fed by a behavioural VRAM model.
module tb_vram_access_ctrl;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_we_i, cpu_re_i;
    logic [15:0]   cpu_addr_i;
    logic [DW-1:0] cpu_data_i, cpu_rdata_i, cpu_rdata_o;
    logic          cpu_rvalid_o;
    logic          fill_start_i, fill_abort_i;
    logic [7:0]    fill_x0_i, fill_x1_i, fill_y0_i, fill_y1_i;
    logic [DW-1:0] fill_color_i;
    logic          fill_busy_o, fill_done_o, fill_err_o;
    logic          vram_we_o, vram_re_o;
    logic [15:0]   vram_addr_o;
    logic [DW-1:0] vram_data_o;

    always #10 clk = ~clk;

    vram_access_ctrl #(.H_RES(200), .V_RES(150), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_we_i(cpu_we_i), .cpu_re_i(cpu_re_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_rdata_i(cpu_rdata_i),
        .cpu_rdata_o(cpu_rdata_o), .cpu_rvalid_o(cpu_rvalid_o),
        .fill_start_i(fill_start_i), .fill_abort_i(fill_abort_i),
        .fill_x0_i(fill_x0_i), .fill_x1_i(fill_x1_i),
        .fill_y0_i(fill_y0_i), .fill_y1_i(fill_y1_i),
        .fill_color_i(fill_color_i),
        .fill_busy_o(fill_busy_o), .fill_done_o(fill_done_o), .fill_err_o(fill_err_o),
        .vram_we_o(vram_we_o), .vram_re_o(vram_re_o),
        .vram_addr_o(vram_addr_o), .vram_data_o(vram_data_o)
    );

    // Behavioural synchronous VRAM
    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] vram_rdata = '0;
    always @(posedge clk) begin
        if (vram_we_o) mem[vram_addr_o] <= vram_data_o;
        if (vram_re_o) vram_rdata <= mem[vram_addr_o];
    end
    assign cpu_rdata_i = vram_rdata;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0]   addr;
        logic [DW-1:0] data;
    } wr_t;
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    wr_t wr_q[$];
    rd_t rd_q[$];
    wr_t we_exp;
    rd_t re_exp;
    bit  sb_on = 1'b1;
    int  n_wr, n_done, n_err, n_busy, first_wr, last_wr;

    always @(negedge clk) begin
        if (rst_n) begin
            if (vram_we_o) begin
                n_wr++;
                if (n_wr == 1) first_wr = cyc;
                last_wr = cyc;
                if (sb_on) begin
                    checks++;
                    if (wr_q.size() == 0) begin
                        errors++;
                        $display("FAIL write_unexpected: got addr=%h data=%h, required no write",
                                 vram_addr_o, vram_data_o);
                    end else begin
                        we_exp = wr_q.pop_front();
                        if (vram_addr_o !== we_exp.addr || vram_data_o !== we_exp.data) begin
                            errors++;
                            $display("FAIL write_seq: got addr=%h data=%h, required addr=%h data=%h",
                                     vram_addr_o, vram_data_o, we_exp.addr, we_exp.data);
                        end
                    end
                end
            end
            if (fill_done_o) n_done++;
            if (fill_err_o)  n_err++;
            if (fill_busy_o) n_busy++;
            if (cpu_rvalid_o) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid_unexpected: got rdata=%h, required no rvalid", cpu_rdata_o);
                end else begin
                    re_exp = rd_q.pop_front();
                    if (cpu_rdata_o !== re_exp.data || cyc != re_exp.due) begin
                        errors++;
                        $display("FAIL read_return: got data=%h cycle=%0d, required data=%h cycle=%0d",
                                 cpu_rdata_o, cyc, re_exp.data, re_exp.due);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic clr();
        n_wr = 0; n_done = 0; n_err = 0; n_busy = 0; first_wr = 0; last_wr = 0;
    endtask

    task automatic push_rect(input int x0, input int x1, input int y0, input int y1,
                             input logic [DW-1:0] col);
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = x0; xx <= x1; xx++)
                wr_q.push_back('{addr: {8'(yy), 8'(xx)}, data: col});
    endtask

    // Called at a negedge; leaves the bench one negedge after the start edge.
    task automatic start_fill(input logic [7:0] x0, input logic [7:0] x1,
                              input logic [7:0] y0, input logic [7:0] y1,
                              input logic [DW-1:0] col);
        fill_x0_i = x0; fill_x1_i = x1; fill_y0_i = y0; fill_y1_i = y1;
        fill_color_i = col;
        fill_start_i = 1'b1;
        @(negedge clk);
        fill_start_i = 1'b0;
    endtask

    typedef struct {
        logic [7:0]    x0, x1, y0, y1;
        logic [DW-1:0] col;
        bit            err;
        int            nwr;
    } vec_t;
    vec_t tv[8];

    initial begin
        tv[0] = '{8'd2,   8'd4,   8'd1,   8'd2,   8'hE0, 1'b0, 6};
        tv[1] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'h11, 1'b0, 1};
        tv[2] = '{8'd0,   8'd199, 8'd149, 8'd149, 8'h22, 1'b0, 200};
        tv[3] = '{8'd197, 8'd199, 8'd147, 8'd149, 8'h33, 1'b0, 9};
        tv[4] = '{8'd0,   8'd200, 8'd0,   8'd0,   8'h44, 1'b1, 0};
        tv[5] = '{8'd0,   8'd0,   8'd5,   8'd3,   8'h55, 1'b1, 0};
        tv[6] = '{8'd5,   8'd4,   8'd0,   8'd0,   8'h66, 1'b1, 0};
        tv[7] = '{8'd0,   8'd0,   8'd150, 8'd150, 8'h77, 1'b1, 0};

        cpu_we_i = 0; cpu_re_i = 0; cpu_addr_i = '0; cpu_data_i = '0;
        fill_start_i = 0; fill_abort_i = 0;
        fill_x0_i = '0; fill_x1_i = '0; fill_y0_i = '0; fill_y1_i = '0; fill_color_i = '0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {2'b0, vram_we_o, vram_re_o, vram_addr_o, vram_data_o, cpu_rvalid_o,
             fill_busy_o, fill_done_o, fill_err_o}, 32'h0);

        // CPU write then read-back of the same address
        cpu_we_i = 1; cpu_addr_i = 16'h0A05; cpu_data_i = 8'h3C;
        wr_q.push_back('{addr: 16'h0A05, data: 8'h3C});
        @(negedge clk);
        cpu_we_i = 0;
        chk("cpu_wr_fwd", {15'b0, vram_we_o, vram_addr_o}, {15'b0, 1'b1, 16'h0A05});
        chk("cpu_wr_data", 32'(vram_data_o), 32'h3C);
        cpu_re_i = 1;
        rd_q.push_back('{data: 8'h3C, due: cyc + 2});
        @(negedge clk);
        cpu_re_i = 0;
        chk("cpu_rd_fwd", {15'b0, vram_re_o, vram_addr_o}, {15'b0, 1'b1, 16'h0A05});
        @(negedge clk);
        chk("cpu_rvalid", {23'b0, cpu_rvalid_o, cpu_rdata_o}, {23'b0, 1'b1, 8'h3C});

        // Simultaneous write and read: write wins, read dropped
        cpu_we_i = 1; cpu_re_i = 1; cpu_addr_i = 16'h0B00; cpu_data_i = 8'h5A;
        wr_q.push_back('{addr: 16'h0B00, data: 8'h5A});
        @(negedge clk);
        cpu_we_i = 0; cpu_re_i = 0;
        chk("we_re_both", {30'b0, vram_we_o, vram_re_o}, 32'h2);
        repeat (3) @(negedge clk);

        // Table-driven fill requests
        for (int i = 0; i < 8; i++) begin
            clr();
            if (!tv[i].err)
                push_rect(int'(tv[i].x0), int'(tv[i].x1), int'(tv[i].y0), int'(tv[i].y1), tv[i].col);
            start_fill(tv[i].x0, tv[i].x1, tv[i].y0, tv[i].y1, tv[i].col);
            repeat (tv[i].nwr + 4) @(negedge clk);
            chk($sformatf("tv%0d_writes", i), 32'(n_wr), 32'(tv[i].nwr));
            chk($sformatf("tv%0d_err", i), 32'(n_err), tv[i].err ? 32'd1 : 32'd0);
            chk($sformatf("tv%0d_done", i), 32'(n_done), tv[i].err ? 32'd0 : 32'd1);
            chk($sformatf("tv%0d_idle", i), 32'(fill_busy_o), 32'd0);
            if (tv[i].err)
                chk($sformatf("tv%0d_busy_cycles", i), 32'(n_busy), 32'd0);
            else
                chk($sformatf("tv%0d_consecutive", i), 32'(last_wr - first_wr + 1), 32'(tv[i].nwr));
            chk($sformatf("tv%0d_sb_empty", i), 32'(wr_q.size()), 32'd0);
        end

        // Fill stalled by two CPU writes in the third slot; a start while busy is ignored
        clr();
        push_rect(2, 3, 1, 1, 8'hE0);
        wr_q.push_back('{addr: 16'h7001, data: 8'hA1});
        wr_q.push_back('{addr: 16'h7002, data: 8'hA2});
        push_rect(4, 4, 1, 1, 8'hE0);
        push_rect(2, 4, 2, 2, 8'hE0);
        start_fill(8'd2, 8'd4, 8'd1, 8'd2, 8'hE0);
        @(negedge clk);
        fill_x0_i = 8'd0; fill_x1_i = 8'd0; fill_y0_i = 8'd0; fill_y1_i = 8'd0;
        fill_start_i = 1'b1;
        @(negedge clk);
        fill_start_i = 1'b0;
        cpu_we_i = 1; cpu_addr_i = 16'h7001; cpu_data_i = 8'hA1;
        @(negedge clk);
        cpu_addr_i = 16'h7002; cpu_data_i = 8'hA2;
        @(negedge clk);
        cpu_we_i = 0;
        repeat (10) @(negedge clk);
        chk("stall_total_writes", 32'(n_wr), 32'd8);
        chk("stall_done", 32'(n_done), 32'd1);
        chk("stall_sb_empty", 32'(wr_q.size()), 32'd0);
        chk("stall_idle", 32'(fill_busy_o), 32'd0);

        // Full-frame fill aborted after exactly 100 writes
        sb_on = 1'b0;
        clr();
        start_fill(8'd0, 8'd199, 8'd0, 8'd149, 8'hC3);
        repeat (100) @(negedge clk);
        fill_abort_i = 1'b1;
        @(negedge clk);
        fill_abort_i = 1'b0;
        chk("abort_busy_drop", 32'(fill_busy_o), 32'd0);
        repeat (5) @(negedge clk);
        chk("abort_writes", 32'(n_wr), 32'd100);
        chk("abort_no_done", 32'(n_done), 32'd0);

        // Asynchronous reset in the middle of a fill
        clr();
        start_fill(8'd0, 8'd199, 8'd0, 8'd149, 8'h81);
        repeat (10) @(negedge clk);
        chk("prereset_active", {30'b0, fill_busy_o, vram_we_o}, 32'h3);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {2'b0, vram_we_o, vram_re_o, vram_addr_o, vram_data_o, cpu_rvalid_o,
             fill_busy_o, fill_done_o, fill_err_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        repeat (6) @(negedge clk);
        chk("postreset_no_writes", 32'(n_wr), 32'd0);
        chk("postreset_no_done", 32'(n_done), 32'd0);
        chk("postreset_idle", 32'(fill_busy_o), 32'd0);

        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
